// File: rtl/memarb.sv
// memarb: two-port memory arbiter; CPU passes straight through with absolute priority,
// the secondary master (debug/DMA) is granted only in CPU-idle cycles.
// Ports: clk, rst (sync, active-high); CPU side c_re/c_we/c_addr/c_wdata -> c_rdata;
// secondary side s_req/s_we/s_addr/s_wdata -> s_gnt/s_rvalid/s_rdata/s_starve;
// memory side m_re/m_we/m_addr/m_wdata <- m_rdata (read data one cycle after address).
// Optional MEMARB_STARVE_EN: builds an 8-bit wait counter driving s_starve once it hits MAXWAIT.
module memarb #(
    parameter int MAXWAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_re,
    input  logic        c_we,
    input  logic [29:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic [31:0] c_rdata,
    input  logic        s_req,
    input  logic        s_we,
    input  logic [29:0] s_addr,
    input  logic [31:0] s_wdata,
    output logic        s_gnt,
    output logic        s_rvalid,
    output logic [31:0] s_rdata,
    output logic        s_starve,
    output logic        m_re,
    output logic        m_we,
    output logic [29:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);
    logic [1:0] rdpipe;
    assign c_rdata  = m_rdata;
    assign s_gnt    = !rst && s_req && !(c_re || c_we);
    assign m_re     = s_gnt ? !s_we : c_re;
    assign m_we     = s_gnt ? s_we : c_we;
    assign m_addr   = s_gnt ? s_addr : c_addr;
    assign m_wdata  = s_gnt ? s_wdata : c_wdata;
    assign s_rvalid = rdpipe[1];
    // rdpipe[0] marks the cycle whose m_rdata belongs to a secondary read,
    // even if the CPU has taken the memory port again in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdpipe  <= 2'b00;
            s_rdata <= 32'h0;
        end else begin
            rdpipe <= {rdpipe[0], s_gnt && !s_we};
            if (rdpipe[0]) s_rdata <= m_rdata;
        end
    end
`ifdef MEMARB_STARVE_EN
    localparam logic [7:0] MW = 8'(MAXWAIT);
    logic [7:0] wait_cnt;
    logic [7:0] wait_nxt;
    // Flag is raised on the same edge the counter reaches the threshold.
    assign wait_nxt = s_gnt ? 8'h00 : (s_req && wait_cnt != 8'hff) ? wait_cnt + 8'h01 : wait_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 8'h00;
            s_starve <= 1'b0;
        end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt >= MW) s_starve <= 1'b1;
        end
    end
`else
    assign s_starve = 1'b0;
`endif
endmodule

// File: tb/tb_memarb.sv
// tb_memarb: directed self-checking bench for memarb.
module tb_memarb;
    logic        clk = 1'b0;
    logic        rst;
    logic        c_re, c_we, s_req, s_we;
    logic [29:0] c_addr, s_addr;
    logic [31:0] c_wdata, s_wdata, m_rdata;
    logic [31:0] c_rdata, s_rdata, m_wdata;
    logic        s_gnt, s_rvalid, s_starve, m_re, m_we;
    logic [29:0] m_addr;
    int n_cmp = 0;
    int n_err = 0;

    memarb #(.MAXWAIT(3)) dut (
        .clk(clk), .rst(rst),
        .c_re(c_re), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_rdata(c_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_starve(s_starve),
        .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; c_re = 0; c_we = 0; c_addr = 30'h7; c_wdata = 32'hA5A5A5A5;
        s_req = 1; s_we = 0; s_addr = 30'h99; s_wdata = 0; m_rdata = 0;
        step(); step(); #1;
        n_cmp++; if (s_gnt !== 1'b0) begin n_err++; $display("FAIL reset_gnt got %b want 0", s_gnt); end
        n_cmp++; if (m_addr !== 30'h7) begin n_err++; $display("FAIL reset_maddr got %h want 7", m_addr); end
        n_cmp++; if (m_re !== 1'b0) begin n_err++; $display("FAIL reset_mre got %b want 0", m_re); end
        n_cmp++; if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid got %b want 0", s_rvalid); end
        n_cmp++; if (s_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", s_rdata); end
        n_cmp++; if (s_starve !== 1'b0) begin n_err++; $display("FAIL reset_starve got %b want 0", s_starve); end
        step(); rst = 0; s_req = 0; c_addr = 0; c_wdata = 0; #1;
        n_cmp++; if (m_re !== 1'b0 || m_we !== 1'b0) begin n_err++; $display("FAIL idle_strobes got %b%b want 00", m_re, m_we); end
    endtask

    task automatic test_read();
        step(); s_req = 1; s_we = 0; s_addr = 30'h10; #1;
        n_cmp++; if (s_gnt !== 1'b1) begin n_err++; $display("FAIL rd_gnt got %b want 1", s_gnt); end
        n_cmp++; if (m_addr !== 30'h10) begin n_err++; $display("FAIL rd_maddr got %h want 10", m_addr); end
        n_cmp++; if (m_re !== 1'b1 || m_we !== 1'b0) begin n_err++; $display("FAIL rd_strobes got %b%b want 10", m_re, m_we); end
        step(); s_req = 0; m_rdata = 32'hDEADBEEF; #1;
        n_cmp++; if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_early_rvalid got %b want 0", s_rvalid); end
        step(); m_rdata = 32'h0; #1;
        n_cmp++; if (s_rvalid !== 1'b1) begin n_err++; $display("FAIL rd_rvalid got %b want 1", s_rvalid); end
        n_cmp++; if (s_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_rdata got %h want deadbeef", s_rdata); end
        step(); #1;
        n_cmp++; if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_pulse got %b want 0", s_rvalid); end
        n_cmp++; if (s_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_hold got %h want deadbeef", s_rdata); end
    endtask

    task automatic test_cpu_priority();
        step(); c_re = 1; c_addr = 30'h4; s_req = 1; s_we = 1; s_addr = 30'h20; s_wdata = 32'hCAFEF00D;
        m_rdata = 32'h12345678; #1;
        n_cmp++; if (s_gnt !== 1'b0) begin n_err++; $display("FAIL pri_gnt got %b want 0", s_gnt); end
        n_cmp++; if (m_addr !== 30'h4) begin n_err++; $display("FAIL pri_maddr got %h want 4", m_addr); end
        n_cmp++; if (m_re !== 1'b1 || m_we !== 1'b0) begin n_err++; $display("FAIL pri_strobes got %b%b want 10", m_re, m_we); end
        n_cmp++; if (c_rdata !== 32'h12345678) begin n_err++; $display("FAIL pri_crdata got %h want 12345678", c_rdata); end
        step(); c_re = 0; m_rdata = 0; #1;
        n_cmp++; if (s_gnt !== 1'b1) begin n_err++; $display("FAIL wr_gnt got %b want 1", s_gnt); end
        n_cmp++; if (m_we !== 1'b1 || m_re !== 1'b0) begin n_err++; $display("FAIL wr_strobes got %b%b want 01", m_re, m_we); end
        n_cmp++; if (m_wdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL wr_wdata got %h want cafef00d", m_wdata); end
        n_cmp++; if (m_addr !== 30'h20) begin n_err++; $display("FAIL wr_maddr got %h want 20", m_addr); end
        step(); s_req = 0; s_we = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL wr_no_rvalid[%0d] got %b want 0", i, s_rvalid); end
            step();
        end
    endtask

    task automatic test_back_to_back();
        s_req = 1; s_we = 0; s_addr = 30'h30; #1;
        n_cmp++; if (s_gnt !== 1'b1) begin n_err++; $display("FAIL b2b_gnt0 got %b want 1", s_gnt); end
        step(); s_addr = 30'h31; m_rdata = 32'h11; #1;
        n_cmp++; if (s_gnt !== 1'b1 || m_addr !== 30'h31) begin n_err++; $display("FAIL b2b_gnt1 got %b/%h want 1/31", s_gnt, m_addr); end
        step(); s_req = 0; m_rdata = 32'h22; #1;
        n_cmp++; if (s_rvalid !== 1'b1 || s_rdata !== 32'h11) begin n_err++; $display("FAIL b2b_first got %b/%h want 1/11", s_rvalid, s_rdata); end
        step(); m_rdata = 0; #1;
        n_cmp++; if (s_rvalid !== 1'b1 || s_rdata !== 32'h22) begin n_err++; $display("FAIL b2b_second got %b/%h want 1/22", s_rvalid, s_rdata); end
        step(); #1;
        n_cmp++; if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL b2b_end got %b want 0", s_rvalid); end
    endtask

    task automatic test_cpu_after_read();
        step(); s_req = 1; s_we = 0; s_addr = 30'h40; #1;
        n_cmp++; if (s_gnt !== 1'b1) begin n_err++; $display("FAIL car_gnt got %b want 1", s_gnt); end
        step(); s_req = 0; c_we = 1; c_addr = 30'h5; c_wdata = 32'h77; m_rdata = 32'h55; #1;
        n_cmp++; if (m_we !== 1'b1 || m_addr !== 30'h5 || m_wdata !== 32'h77) begin n_err++; $display("FAIL car_cpu got %b/%h/%h want 1/5/77", m_we, m_addr, m_wdata); end
        step(); c_we = 0; c_addr = 0; c_wdata = 0; m_rdata = 0; #1;
        n_cmp++; if (s_rvalid !== 1'b1 || s_rdata !== 32'h55) begin n_err++; $display("FAIL car_ret got %b/%h want 1/55", s_rvalid, s_rdata); end
    endtask

    task automatic test_reset_midflight();
        step(); s_req = 1; s_we = 0; s_addr = 30'h50; #1;
        n_cmp++; if (s_gnt !== 1'b1) begin n_err++; $display("FAIL rmf_gnt got %b want 1", s_gnt); end
        step(); s_req = 0; rst = 1; m_rdata = 32'h99;
        step(); rst = 0; m_rdata = 0; #1;
        n_cmp++; if (s_rvalid !== 1'b0 || s_rdata !== 32'h0) begin n_err++; $display("FAIL rmf_drop got %b/%h want 0/0", s_rvalid, s_rdata); end
        step(); #1;
        n_cmp++; if (s_rvalid !== 1'b0) begin n_err++; $display("FAIL rmf_late got %b want 0", s_rvalid); end
    endtask

    task automatic test_starve();
        logic exp_set;
`ifdef MEMARB_STARVE_EN
        exp_set = 1'b1;
`else
        exp_set = 1'b0;
`endif
        step(); c_re = 1; c_addr = 30'h8; s_req = 1; s_we = 0; s_addr = 30'h60;
        for (int i = 0; i < 2; i++) begin
            step(); #1;
            n_cmp++; if (s_starve !== 1'b0) begin n_err++; $display("FAIL stv_early[%0d] got %b want 0", i, s_starve); end
        end
        step(); #1;
        n_cmp++; if (s_starve !== exp_set) begin n_err++; $display("FAIL stv_set got %b want %b", s_starve, exp_set); end
        c_re = 0; #1;
        n_cmp++; if (s_gnt !== 1'b1) begin n_err++; $display("FAIL stv_gnt got %b want 1", s_gnt); end
        step(); s_req = 0; #1;
        n_cmp++; if (s_starve !== exp_set) begin n_err++; $display("FAIL stv_sticky got %b want %b", s_starve, exp_set); end
        step(); step(); rst = 1;
        step(); rst = 0; #1;
        n_cmp++; if (s_starve !== 1'b0) begin n_err++; $display("FAIL stv_clear got %b want 0", s_starve); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_cpu_priority();
        test_back_to_back();
        test_cpu_after_read();
        test_reset_midflight();
        test_starve();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
